// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register file's single write port between NUM_REQ writeback requesters and the JAL link write.
// Keeps a pending-write scoreboard for RAW stalls; define WB_SCHED_ROUND_ROBIN_EN for round-robin arbitration.
module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      jal_valid,
  input  logic [DATA_W-1:0]         jal_link,
  input  logic                      claim_valid,
  input  logic [ADDR_W-1:0]         claim_addr,
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic [ADDR_W-1:0]         rt_addr,
  output logic                      rs_busy,
  output logic                      rt_busy,
  output logic                      wr_en,
  output logic                      JumpAndLink,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [DATA_W-1:0]         link_addr
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_REG = ADDR_W'(NREG - 1);

  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [NREG-1:0]    pending;
  logic [NREG-1:0]    pending_nxt;

`ifdef WB_SCHED_ROUND_ROBIN_EN
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic             found;

  // First pass covers indices at or above the pointer, second pass wraps to the bottom.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!jal_valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rr_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
    end
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!jal_valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

  assign any_grant = |grant;
  assign req_ready = rst_n ? grant : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Claims are applied after clears so a same-edge claim of the retiring register stays pending.
  always_comb begin
    pending_nxt = pending;
    if (jal_valid) begin
      pending_nxt[LINK_REG] = 1'b0;
    end else if (any_grant) begin
      pending_nxt[sel_addr] = 1'b0;
    end
    if (claim_valid) begin
      pending_nxt[claim_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // wr_en stays high for the link write so the regfile's JAL bypass path fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      JumpAndLink <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      link_addr   <= '0;
    end else if (jal_valid) begin
      wr_en       <= 1'b1;
      JumpAndLink <= 1'b1;
      wr_addr     <= LINK_REG;
      link_addr   <= jal_link;
    end else if (any_grant) begin
      wr_en       <= 1'b1;
      JumpAndLink <= 1'b0;
      wr_addr     <= sel_addr;
      wr_data     <= sel_data;
    end else begin
      wr_en       <= 1'b0;
      JumpAndLink <= 1'b0;
    end
  end

  // A write sitting in the output stage lands in the regfile this cycle, so it no longer blocks readers.
  assign rs_busy = (rs_addr != '0) && pending[rs_addr] && !(wr_en && (wr_addr == rs_addr));
  assign rt_busy = (rt_addr != '0) && pending[rt_addr] && !(wr_en && (wr_addr == rt_addr));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized bench for regfile_wb_scheduler against a behavioural model of arbitration, output stage and scoreboard.
module tb_regfile_wb_scheduler;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            jal_valid;
  logic [DW-1:0]   jal_link;
  logic            claim_valid;
  logic [AW-1:0]   claim_addr;
  logic [AW-1:0]   rs_addr;
  logic [AW-1:0]   rt_addr;
  logic            rs_busy;
  logic            rt_busy;
  logic            wr_en;
  logic            JumpAndLink;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   link_addr;

  regfile_wb_scheduler #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .jal_valid(jal_valid), .jal_link(jal_link),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .wr_en(wr_en), .JumpAndLink(JumpAndLink), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // requester holding registers and reference model state
  bit          hv[N];
  logic [4:0]  ha[N];
  logic [31:0] hd[N];
  bit          pend[32];
  int          ptr;
  bit          m_en, m_jal;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_link;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (jal_valid) return -1;
`ifdef WB_SCHED_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) begin
      if (hv[(ptr + k) % N]) return (ptr + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (hv[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic bit exp_busy(input logic [4:0] x);
    if (x == 0) return 1'b0;
    return pend[x] && !(m_en && m_addr == x);
  endfunction

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 9);
    return (r > 7) ? 5'd31 : 5'(r);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    ptr = 0; m_en = 0; m_jal = 0; m_addr = 0; m_data = 0; m_link = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = hv[i];
      req_addr[i*AW +: AW]   = ha[i];
      req_data[i*DW +: DW]   = hd[i];
    end
  endtask

  // Starts just after a falling edge; ends at the next falling edge with outputs checked.
  task automatic run_cycle();
    int g;
    drive();
    #1;
    g = exp_grant();
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    chk("rs_busy", rs_busy, exp_busy(rs_addr));
    chk("rt_busy", rt_busy, exp_busy(rt_addr));
    @(posedge clk);
    if (jal_valid) begin
      m_en = 1; m_jal = 1; m_addr = 31; m_link = jal_link; pend[31] = 0;
    end else if (g >= 0) begin
      m_en = 1; m_jal = 0; m_addr = ha[g]; m_data = hd[g];
      if (ha[g] != 0) pend[ha[g]] = 0;
      hv[g] = 0;
      ptr = (g + 1) % N;
    end else begin
      m_en = 0; m_jal = 0;
    end
    if (claim_valid && claim_addr != 0) pend[claim_addr] = 1;
    @(negedge clk);
    chk("wr_en", wr_en, m_en);
    chk("JumpAndLink", JumpAndLink, m_jal);
    chk("wr_addr", wr_addr, m_addr);
    chk("link_addr", link_addr, m_link);
    if (m_en && !m_jal) chk("wr_data", wr_data, m_data);
  endtask

  task automatic quiet();
    jal_valid = 0; claim_valid = 0;
  endtask

  task automatic drain();
    quiet();
    repeat (N + 1) run_cycle();
  endtask

  initial begin
    rst_n = 0;
    req_valid = '0; req_addr = '0; req_data = '0;
    jal_valid = 0; jal_link = '0; claim_valid = 0; claim_addr = '0;
    rs_addr = '0; rt_addr = '0;
    for (int i = 0; i < N; i++) begin hv[i] = 0; ha[i] = '0; hd[i] = '0; end
    model_reset();
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_jal", JumpAndLink, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_link", link_addr, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1;

    // contention: all three requesters held valid for three cycles
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hv[i]) begin hv[i] = 1; ha[i] = 5'(i + 1); hd[i] = 32'h100 + i; end
      end
      run_cycle();
`ifdef WB_SCHED_ROUND_ROBIN_EN
      chk("contend_addr", wr_addr, c + 1);
`else
      chk("contend_addr", wr_addr, 1);
`endif
    end
    drain();

    // single requester
    hv[1] = 1; ha[1] = 5; hd[1] = 32'hDEADBEEF;
    run_cycle();
    chk("single_en", wr_en, 1);
    chk("single_addr", wr_addr, 5);
    chk("single_data", wr_data, 32'hDEADBEEF);

    // JAL beats pending requesters
    hv[0] = 1; ha[0] = 2; hd[0] = 32'h22;
    hv[1] = 1; ha[1] = 3; hd[1] = 32'h33;
    jal_valid = 1; jal_link = 32'h400;
    run_cycle();
    chk("jal_sel", JumpAndLink, 1);
    chk("jal_en", wr_en, 1);
    chk("jal_addr", wr_addr, 31);
    chk("jal_link", link_addr, 32'h400);
    drain();

    // scoreboard claim, write-through, same-edge set/clear
    rs_addr = 7; rt_addr = 0;
    claim_valid = 1; claim_addr = 7;
    run_cycle();
    claim_valid = 0;
    chk("sb_busy", rs_busy, 1);
    hv[0] = 1; ha[0] = 7; hd[0] = 32'h77;
    run_cycle();
    chk("sb_writethru", rs_busy, 0);
    claim_valid = 1; claim_addr = 7;
    hv[0] = 1; ha[0] = 7; hd[0] = 32'h78;
    run_cycle();
    claim_valid = 0;
    chk("sb_setwin_wt", rs_busy, 0);
    run_cycle();
    chk("sb_setwin", rs_busy, 1);

    // r0 never pending, write still drained
    claim_valid = 1; claim_addr = 0; rs_addr = 0;
    hv[0] = 1; ha[0] = 0; hd[0] = 32'h55;
    run_cycle();
    claim_valid = 0;
    chk("r0_en", wr_en, 1);
    chk("r0_addr", wr_addr, 0);
    chk("r0_busy", rs_busy, 0);

    // async reset mid-stream
    claim_valid = 1; claim_addr = 9;
    run_cycle();
    claim_valid = 0;
    rs_addr = 9; rt_addr = 7;
    for (int i = 0; i < N; i++) begin
      if (!hv[i]) begin hv[i] = 1; ha[i] = rnd_reg(); hd[i] = $urandom; end
    end
    drive();
    #2;
    rst_n = 0;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_rs_busy", rs_busy, 0);
    chk("arst_rt_busy", rt_busy, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hv[i] && $urandom_range(0, 1) == 1) begin
          hv[i] = 1; ha[i] = rnd_reg(); hd[i] = $urandom;
        end
      end
      jal_valid   = ($urandom_range(0, 5) == 0);
      jal_link    = $urandom;
      claim_valid = ($urandom_range(0, 1) == 1);
      claim_addr  = rnd_reg();
      rs_addr     = rnd_reg();
      rt_addr     = rnd_reg();
      run_cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
